// File: rtl/sr_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sr_ctrl_pkg
// Shared types and constants for the SR latch controller.
//   state_t  : sequencing states IDLE -> PULSE -> SETTLE -> DONE -> IDLE
//   OP_SET   : operation code driving latch Q to 1
//   OP_CLR   : operation code driving latch Q to 0
//   max_int  : elaboration-time helper for counter sizing
// -----------------------------------------------------------------------------
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_latch_ctrl_if.sv
// -----------------------------------------------------------------------------
// sr_latch_ctrl_if
// Requester-side bundle of the SR latch controller.
//   req  : per-requester request level, held until gnt
//   op   : per-requester operation (1 = set, 0 = clear), sampled at grant capture
//   gnt  : one-cycle completion pulse to the served requester
//   busy : operation in flight (grant capture through the gnt cycle)
//   err  : sticky latch-verify mismatch flag
// Modports: master = requester side, slave = controller side.
// -----------------------------------------------------------------------------
interface sr_latch_ctrl_if #(
  parameter int N_REQ = 4
) ();

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] op;
  logic [N_REQ-1:0] gnt;
  logic             busy;
  logic             err;

  modport master (
    output req,
    output op,
    input  gnt,
    input  busy,
    input  err
  );

  modport slave (
    input  req,
    input  op,
    output gnt,
    output busy,
    output err
  );

endinterface

// File: rtl/sr_latch_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the lowest requesting index at or after ptr,
// wrapping past N-1 back to 0.
//   req : request vector
//   ptr : index that has first priority
//   win : winning index (0 when nothing requests)
//   any : at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] win,
  output logic             any
);

  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default before any branch, so no
    // path through the block leaves a value held and no latch is inferred.
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[IDX_W'(idx)]) begin
        any = 1'b1;
        win = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sr_latch_ctrl.sv
// -----------------------------------------------------------------------------
// sr_latch_ctrl
// Sequences set/clear operations from N_REQ synchronous requesters onto one
// external NAND SR latch (active-low inputs). One operation is in flight; the
// winner is chosen round-robin. Each operation drives one latch input low for
// PULSE_CYC cycles, holds both inputs high for SETTLE_CYC cycles, then pulses
// gnt for one cycle.
//
// Ports
//   clk           : clock, all state on the rising edge
//   rst_n         : asynchronous active-low reset
//   bus           : requester bundle (req, op, gnt, busy, err), slave side
//   latch_set_n   : latch set input, active low, registered
//   latch_reset_n : latch reset input, active low, registered
//   latch_q       : latch Q feedback, used only with verification enabled
//
// Configuration
//   SR_CTRL_VERIFY_EN : when defined, latch_q is synchronised through two flops
//                       and compared with the operation in DONE; a mismatch sets
//                       the sticky err flag. When undefined err is tied to 0.
// -----------------------------------------------------------------------------
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sr_latch_ctrl_if.slave       bus,
  output logic                 latch_set_n,
  output logic                 latch_reset_n,
  input  logic                 latch_q
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(max_int(PULSE_CYC, SETTLE_CYC) + 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic               op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic               busy_q, busy_d;
  logic               set_n_d, reset_n_d;

  logic [IDX_W-1:0]   arb_win;
  logic               arb_any;
  logic               op_sel;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (bus.req),
    .ptr (ptr_q),
    .win (arb_win),
    .any (arb_any)
  );

  assign op_sel = bus.op[arb_win];

  // Next-state and next-output logic. The latch drives are computed for the
  // state being entered so that the registered outputs line up exactly with
  // the state in which they are meant to be seen.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    gnt_d     = '0;
    busy_d    = busy_q;
    set_n_d   = 1'b1;
    reset_n_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d   = PULSE;
          win_d     = arb_win;
          op_d      = op_sel;
          cnt_d     = CNT_W'(PULSE_CYC - 1);
          busy_d    = 1'b1;
          set_n_d   = (op_sel != OP_SET);
          reset_n_d = (op_sel == OP_SET);
        end
      end

      PULSE: begin
        if (cnt_q == '0) begin
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYC - 1);
        end else begin
          cnt_d     = cnt_q - 1'b1;
          set_n_d   = (op_q != OP_SET);
          reset_n_d = (op_q == OP_SET);
        end
      end

      SETTLE: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          gnt_d   = N_REQ'(1) << win_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      win_q         <= '0;
      op_q          <= OP_CLR;
      cnt_q         <= '0;
      gnt_q         <= '0;
      busy_q        <= 1'b0;
      latch_set_n   <= 1'b1;
      latch_reset_n <= 1'b1;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      win_q         <= win_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      busy_q        <= busy_d;
      latch_set_n   <= set_n_d;
      latch_reset_n <= reset_n_d;
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;

`ifdef SR_CTRL_VERIFY_EN
  // latch_q comes from an unclocked primitive, so it is brought into the clock
  // domain through two flops before being compared. By DONE the pulse edge is
  // at least PULSE_CYC + SETTLE_CYC cycles old, which covers the sync latency.
  logic q_meta, q_sync, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta <= 1'b0;
      q_sync <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_meta <= latch_q;
      q_sync <= q_meta;
      if (state_q == DONE && q_sync != op_q) err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_latch_q;
  assign unused_latch_q = latch_q;
  assign bus.err        = 1'b0;
`endif

  // Both latch inputs low would force Q = Qb = 1 and leave the latch in an
  // undefined state on release; the FSM never drives that combination.
  a_never_both_low: assert property (
    @(posedge clk) disable iff (!rst_n) (latch_set_n || latch_reset_n)
  );

endmodule
